// File: rtl/des_subkey_sched_pkg.sv
// DES key-schedule package: widths, FSM state type, PC1/PC2 and shift tables,
// and the 28-bit rotate / PC1 helpers. Shared with the Feistel round pipeline.
package des_subkey_sched_pkg;

  localparam int unsigned KEY_W       = 64;
  localparam int unsigned CD_W        = 56;
  localparam int unsigned HALF_W      = 28;
  localparam int unsigned SUBKEY_W    = 48;
  localparam int unsigned ROUND_W     = 4;
  localparam int unsigned NUM_SUBKEYS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // FIPS 46-3 PC1: entry i gives the 1-based key bit feeding CD bit i+1
  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // FIPS 46-3 PC2: entry i gives the 1-based CD bit feeding subkey bit i+1
  localparam int unsigned PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-shift amount for rounds 1..16 (index 0 = round 1)
  localparam logic [1:0] SHIFT_SCHED [NUM_SUBKEYS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Circular left rotate of one 28-bit half by 1 or 2
  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                               input logic [1:0]        s);
    return (s == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                       : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  // Circular right rotate of one 28-bit half by 1 or 2
  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                               input logic [1:0]        s);
    return (s == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                       : {x[0], x[HALF_W-1:1]};
  endfunction

  // PC1 on an MSB-first key (bit 63 = FIPS bit 1); parity bits drop out
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CD_W); i++) begin
      r[6'(int'(CD_W) - 1 - i)] = key[6'(KEY_W - PC1_TAB[i])];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_subkey_sched_if.sv
// Key-in / subkey-out bus of the DES key schedule.
// master: front end + round pipeline side; slave: des_subkey_sched.
interface des_subkey_sched_if;
  import des_subkey_sched_pkg::*;

  logic                  start;
  logic                  decrypt;
  logic [KEY_W-1:0]      key_in;
  logic                  busy;
  logic [SUBKEY_W-1:0]   subkey;
  logic [ROUND_W-1:0]    subkey_round;
  logic                  subkey_valid;
  logic                  subkey_ready;
  logic                  done;

  modport master (
    output start, decrypt, key_in, subkey_ready,
    input  busy, subkey, subkey_round, subkey_valid, done
  );

  modport slave (
    input  start, decrypt, key_in, subkey_ready,
    output busy, subkey, subkey_round, subkey_valid, done
  );

endinterface

// File: rtl/des_pc2.sv
// DES PC2 permutation: 56-bit C||D (MSB = FIPS bit 1) to 48-bit subkey.
// Ports: cd in [55:0], subkey out [47:0]. Purely combinational.
module des_pc2
  import des_subkey_sched_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < int'(SUBKEY_W); i++) begin
      subkey[6'(int'(SUBKEY_W) - 1 - i)] = cd[6'(CD_W - PC2_TAB[i])];
    end
  end

endmodule

// File: rtl/des_subkey_sched.sv
// Sequential DES key schedule: latches a key on start and streams K1..K16
// (encrypt) or K16..K1 (decrypt, via right rotation) over valid/ready.
// Ports: clk, rst (async active-high), bus (slave): start/decrypt/key_in in,
// busy/done status, subkey/subkey_round/subkey_valid out with subkey_ready in.
module des_subkey_sched
  import des_subkey_sched_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS          = 16,
  parameter bit          BIT_ORDER_MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  des_subkey_sched_if.slave   bus
);

  if (NUM_ROUNDS != NUM_SUBKEYS) begin : g_num_rounds_check
    $error("des_subkey_sched: NUM_ROUNDS must be 16");
  end

  sched_state_t          state_q, state_d;
  logic                  dec_q, dec_d;
  logic [HALF_W-1:0]     c_q, c_d;
  logic [HALF_W-1:0]     d_q, d_d;
  logic [ROUND_W-1:0]    count_q, count_d;
  logic [ROUND_W-1:0]    round_q, round_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [SUBKEY_W-1:0]   subkey_q, subkey_d;

  logic [KEY_W-1:0]      key_fips;
  logic [CD_W-1:0]       cd0;
  logic [SUBKEY_W-1:0]   subkey_fips;
  logic                  xfer;

  // Normalise key bit order so the tables always see FIPS bit 1 at the MSB
  always_comb begin
    if (BIT_ORDER_MSB_FIRST) key_fips = bus.key_in;
    else                     key_fips = {<<{bus.key_in}};
  end

  assign cd0  = pc1(key_fips);
  assign xfer = valid_q && bus.subkey_ready;

  // Next-state and next C/D: C/D always holds the pair being presented
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    c_d     = c_q;
    d_d     = d_q;
    count_d = count_q;
    round_d = round_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        if (bus.start) begin
          state_d = RUN;
          dec_d   = bus.decrypt;
          count_d = '0;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          if (bus.decrypt) begin
            // Total rotation over 16 rounds is 28, so C16/D16 == C0/D0
            c_d     = cd0[CD_W-1:HALF_W];
            d_d     = cd0[HALF_W-1:0];
            round_d = ROUND_W'(NUM_SUBKEYS - 1);
          end else begin
            c_d     = rotl28(cd0[CD_W-1:HALF_W], SHIFT_SCHED[0]);
            d_d     = rotl28(cd0[HALF_W-1:0], SHIFT_SCHED[0]);
            round_d = '0;
          end
        end
      end

      RUN: begin
        if (xfer) begin
          if (count_q == ROUND_W'(NUM_SUBKEYS - 1)) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            count_d = count_q + ROUND_W'(1);
            if (dec_q) begin
              // Undo the shift of the round just presented
              c_d     = rotr28(c_q, SHIFT_SCHED[round_q]);
              d_d     = rotr28(d_q, SHIFT_SCHED[round_q]);
              round_d = round_q - ROUND_W'(1);
            end else begin
              c_d     = rotl28(c_q, SHIFT_SCHED[ROUND_W'(round_q + ROUND_W'(1))]);
              d_d     = rotl28(d_q, SHIFT_SCHED[ROUND_W'(round_q + ROUND_W'(1))]);
              round_d = round_q + ROUND_W'(1);
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Subkey register is fed from the next C/D so it tracks the presented pair
  des_pc2 u_pc2 (
    .cd     ({c_d, d_d}),
    .subkey (subkey_fips)
  );

  always_comb begin
    if (BIT_ORDER_MSB_FIRST) subkey_d = subkey_fips;
    else                     subkey_d = {<<{subkey_fips}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dec_q    <= 1'b0;
      c_q      <= '0;
      d_q      <= '0;
      count_q  <= '0;
      round_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      subkey_q <= '0;
    end else begin
      state_q  <= state_d;
      dec_q    <= dec_d;
      c_q      <= c_d;
      d_q      <= d_d;
      count_q  <= count_d;
      round_q  <= round_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      subkey_q <= subkey_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.subkey       = subkey_q;
  assign bus.subkey_round = round_q;
  assign bus.subkey_valid = valid_q;
  assign bus.done         = done_q;

endmodule

// File: doc/des_subkey_sched.md
Name: des_subkey_sched

Overview:
- Sequential DES key schedule. Accepts one 64-bit key and streams the sixteen 48-bit round subkeys to the round/S-box datapath over a valid/ready handshake.
- In encrypt mode the order is K1..K16. In decrypt mode the order is K16..K1, produced by right-rotation of C/D, so no key RAM or reversal buffer is needed.
- Sits between the serial-command front end, which delivers the key, and the Feistel round pipeline, which consumes the subkeys.

Parameters:
- BIT_ORDER_MSB_FIRST, 1, bit 63 of key_in is FIPS key bit 1 and bit 47 of subkey is FIPS subkey bit 1.
- NUM_ROUNDS, 16, number of subkeys emitted per start. Fixed at 16; any other value is illegal and is caught by an elaboration assertion.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a new schedule; sampled only in IDLE.
- decrypt  in  1  0 = encrypt order K1..K16, 1 = decrypt order K16..K1; sampled with start.
- key_in  in  64  DES key including parity bits; parity bits are ignored; sampled with start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- subkey  out  48  current round subkey.
- subkey_round  out  4  FIPS index of the presented subkey minus 1 (0 = K1 … 15 = K16).
- subkey_valid  out  1  subkey and subkey_round are valid.
- subkey_ready  in  1  consumer accepts the subkey when it is high together with subkey_valid.
- done  out  1  one-cycle pulse after the last subkey is accepted.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; C, D, count, busy, subkey, subkey_round, subkey_valid and done all 0.
- States and transitions:
  - IDLE: on start=1, latch decrypt, compute PC1(key_in) into C0/D0 and go to RUN.
  - RUN: on a transfer (subkey_valid && subkey_ready), advance. After the 16th transfer, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1; next cycle return to IDLE.
- Latency:
  - First subkey is presented with subkey_valid=1 in the first cycle of RUN, one cycle after start.
  - With subkey_ready held high, one subkey per cycle: 16 consecutive valid cycles, then the done pulse.
- Shift schedule s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt order:
  - Presented Cn/Dn = rotl(Cn-1/Dn-1, s[n]).
  - subkey = PC2(Cn,Dn); subkey_round = n-1.
- Decrypt order:
  - First output is K16 = PC2(C0,D0), since the total rotation is 28.
  - Each following step applies rotr by s[n+1] to go from Cn+1/Dn+1 to Cn/Dn.
  - subkey_round counts 15 down to 0.
- Register rule: the C/D register holds the pair currently presented. The next pair is computed combinationally and loaded on transfer.
- Output stability: while subkey_valid && !subkey_ready, subkey and subkey_round stay stable (no stall limit).
- subkey_valid never deasserts in RUN without a transfer.
- start while busy is ignored; key_in and decrypt changes while busy have no effect.
- start asserted in the same cycle as done: ignored, and must be re-presented in IDLE.
- Reset mid-operation aborts immediately; no done pulse is produced.
- Rotations are 28-bit circular within C and within D independently.

Decomposition:
- des_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries), as constant arrays.
  - SHIFT_SCHED constant (16 x 2-bit).
  - sched_state_t enum {IDLE, RUN, DONE}.
  - 28-bit rotl/rotr functions.
- One combinational sub-module, des_pc2: 56-bit CD in, 48-bit subkey out. The round pipeline reuses the same package tables.

Test Plan:
- FIPS key 0x133457799BBCDFF1, decrypt=0, subkey_ready=1 -> cycle+1: subkey=0x1B02EFFC7072 with round=0; 16th valid: subkey=0xCB3D8B0E17F5 with round=15; done pulses the next cycle.
- Same key, decrypt=1 -> first subkey=0xCB3D8B0E17F5 with round=15; last subkey=0x1B02EFFC7072 with round=0; full sequence equals the exact reverse of the encrypt run (checked by scoreboard).
- Backpressure: subkey_ready low for 5 cycles at round 3 -> subkey/subkey_round stable throughout; no skipped or duplicated subkey; 16 transfers total.
- start pulsed mid-RUN with a different key -> ignored; output sequence is unchanged.
- rst asserted asynchronously mid-clock at round 7 -> all outputs 0 immediately, no done pulse; a new start then produces K1 again.
- Key 0x0101010101010101 (weak key, parity ignored) -> all 16 subkeys = 0x000000000000 in both modes; key 0xFEFEFEFEFEFEFEFE -> all subkeys = 0xFFFFFFFFFFFF.
